// File: rtl/pc_stack_if.sv
// Control-unit <-> program-counter bundle: sequencing strobes and branch target in,
// current PC and return-stack status out.
interface pc_stack_if #(
  parameter int Psize = 8,
  parameter int Depth = 4
);
  logic                         stall;
  logic                         PCincr;
  logic                         PCrelbranch;
  logic                         PCjump;
  logic                         PCcall;
  logic                         PCret;
  logic [Psize-1:0]             Branchaddr;
  logic [Psize-1:0]             PCout;
  logic [$clog2(Depth+1)-1:0]   sp;
  logic                         stack_full;
  logic                         stack_empty;
  logic                         stack_err;

  modport master (
    output stall, PCincr, PCrelbranch, PCjump, PCcall, PCret, Branchaddr,
    input  PCout, sp, stack_full, stack_empty, stack_err
  );

  modport slave (
    input  stall, PCincr, PCrelbranch, PCjump, PCcall, PCret, Branchaddr,
    output PCout, sp, stack_full, stack_empty, stack_err
  );
endinterface

// File: rtl/pc_stack.sv
// Program counter with increment, relative branch, jump, and call/return through a
// return-address LIFO of Depth entries; overflow/underflow set a sticky error flag.
module pc_stack #(
  parameter int Psize = 8,
  parameter int Depth = 4
) (
  input logic        clk,
  input logic        reset,
  pc_stack_if.slave  bus
);
  localparam int SPW = $clog2(Depth + 1);
  localparam int IW  = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [SPW-1:0] SP_MAX = SPW'(Depth);

  logic        [Psize-1:0] pc_p0;
  logic        [SPW-1:0]   sp_p0;
  logic                    err_p0;
  logic        [Psize-1:0] stack_p0 [Depth];

  logic signed [Psize-1:0] operand;
  logic        [Psize-1:0] sum;
  logic        [SPW-1:0]   sp_dec;
  logic        [IW-1:0]    wr_idx;
  logic        [IW-1:0]    rd_idx;
  logic                    active, full, empty, sel_rel;
  logic                    push, pop, ovf, unf, seq_op;

  function automatic logic [Psize-1:0] wrap_add(input logic        [Psize-1:0] base,
                                                input logic signed [Psize-1:0] off);
    wrap_add = base + $unsigned(off);
  endfunction

  assign active = ~bus.stall;
  assign full   = (sp_p0 == SP_MAX);
  assign empty  = (sp_p0 == '0);

  // One adder serves increment, relative branch and the call return address (PC+1).
  assign sel_rel = bus.PCrelbranch & ~bus.PCjump & ~bus.PCcall & ~bus.PCret;
  assign operand = sel_rel ? $signed(bus.Branchaddr) : $signed(Psize'(1));
  assign sum     = wrap_add(pc_p0, operand);

  assign pop    = active &  bus.PCret & ~empty;
  assign unf    = active &  bus.PCret &  empty;
  assign push   = active & ~bus.PCret &  bus.PCcall & ~full;
  assign ovf    = active & ~bus.PCret &  bus.PCcall &  full;
  assign seq_op = active & ~bus.PCret & ~bus.PCcall;

  assign sp_dec = sp_p0 - 1'b1;
  assign rd_idx = sp_dec[IW-1:0];
  assign wr_idx = sp_p0[IW-1:0];

  // Stage p0: registered PC, stack pointer and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_p0  <= '0;
      sp_p0  <= '0;
      err_p0 <= 1'b0;
    end else begin
      if (ovf | unf)
        err_p0 <= 1'b1;
      if (pop) begin
        pc_p0 <= stack_p0[rd_idx];
        sp_p0 <= sp_dec;
      end else if (push) begin
        pc_p0 <= bus.Branchaddr;
        sp_p0 <= sp_p0 + 1'b1;
      end else if (seq_op) begin
        if (bus.PCjump)
          pc_p0 <= bus.Branchaddr;
        else if (bus.PCrelbranch | bus.PCincr)
          pc_p0 <= sum;
      end
    end
  end

  // Return-address storage carries no reset; entries above sp are never read.
  always_ff @(posedge clk) begin
    if (push)
      stack_p0[wr_idx] <= sum;
  end

  assign bus.PCout       = pc_p0;
  assign bus.sp          = sp_p0;
  assign bus.stack_full  = full;
  assign bus.stack_empty = empty;
  assign bus.stack_err   = err_p0;
endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter for the embedded processor core.
- Supports increment, signed relative branch, absolute jump, subroutine call and return.
- Holds return addresses in an internal LIFO of configurable depth.
- Sits between the control unit (which drives one-hot-ish control strobes) and instruction memory (which is addressed by PCout).

Parameters:
Psize, 8, PC and address width in bits; the program space is 2^Psize instructions.
Depth, 4, number of return-address stack entries; minimum 1.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-low reset.
stall  input  1  freezes PC and stack when high.
PCincr  input  1  PC <= PC + 1.
PCrelbranch  input  1  PC <= PC + signed Branchaddr.
PCjump  input  1  PC <= Branchaddr (absolute).
PCcall  input  1  push PC+1; PC <= Branchaddr.
PCret  input  1  PC <= popped return address.
Branchaddr  input  Psize  relative offset (two's complement) or absolute target, depending on the strobe.
PCout  output  Psize  current PC.
sp  output  clog2(Depth+1)  number of valid stack entries.
stack_full  output  1  sp == Depth (combinational from sp).
stack_empty  output  1  sp == 0 (combinational from sp).
stack_err  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset (reset low, asynchronous):
  - PCout = 0, sp = 0, stack_err = 0.
  - Stack contents are don't-care.
  - Reset asserted mid-call or mid-return discards the operation entirely.
- All updates occur on the rising clk edge; PCout is registered, with 1-cycle latency from strobe to new PC.
- Priority per cycle: stall > PCret > PCcall > PCjump > PCrelbranch > PCincr. Only the winning operation takes effect.
- stall high: PCout, sp, stack and stack_err all hold.
- No strobe active: PCout holds.
- PCincr: PCout <= PCout + 1, modulo 2^Psize (2^Psize-1 wraps to 0).
- PCrelbranch:
  - Branchaddr is sign-extended, two's complement; PCout <= PCout + Branchaddr, modulo 2^Psize.
  - Backward branch example: Branchaddr = all ones gives PC - 1.
  - The increment and the relative branch share one adder; the operand mux selects 1 or Branchaddr.
- PCjump: PCout <= Branchaddr; the stack is untouched.
- PCcall with sp < Depth:
  - stack[sp] <= PCout + 1 (mod 2^Psize).
  - sp <= sp + 1.
  - PCout <= Branchaddr.
- PCcall with sp == Depth (overflow):
  - No push; PCout holds; sp holds.
  - stack_err <= 1.
- PCret with sp > 0:
  - PCout <= stack[sp-1].
  - sp <= sp - 1.
- PCret with sp == 0 (underflow):
  - PCout holds; sp holds.
  - stack_err <= 1.
- PCcall and PCret asserted in the same cycle: the return wins and the call is ignored. No push/pop combination is performed.
- stack_err:
  - Sticky; cleared only by reset.
  - Does not block later valid operations.
- Stack storage: registers indexed by sp. No read-before-write hazard exists because at most one push or one pop happens per cycle.

Test Plan:
- Reset then 3 cycles of PCincr (Psize=8) -> PCout 0,1,2,3. Assert reset asynchronously between clock edges -> PCout = 0 immediately.
- PCout = 0x10, PCrelbranch with Branchaddr = 0xFC -> PCout = 0x0C. From PCout = 0xFE, PCincr twice -> 0xFF, then 0x00 (wrap).
- PCout = 0x05, PCcall with Branchaddr = 0x40 -> PCout = 0x40, sp = 1. Then PCret -> PCout = 0x06, sp = 0, stack_empty = 1.
- Nested calls from 0x01, 0x11, 0x21, 0x31 (Depth = 4) -> stack_full = 1. A fifth PCcall -> PCout unchanged, stack_err = 1. Four PCrets -> PCout 0x32, 0x22, 0x12, 0x02.
- PCret at sp = 0 -> PCout holds, stack_err = 1. A subsequent PCjump to 0x80 -> PCout = 0x80 and stack_err stays 1.
- stall held 2 cycles with PCincr and PCcall asserted -> no change in PCout or sp. PCcall and PCret together with sp = 1, top entry = 0x09 -> PCout = 0x09, sp = 0.
